// File: rtl/rs_pkg.sv
// Shared reservation-station types: operand slot, entry, result-bus broadcast,
// ALU opcode encoding and the operand wakeup helper reused by every RS flavour.
package rs_pkg;

    localparam int RS_XPR_LEN      = 32;
    localparam int RS_ALU_OP_WIDTH = 4;
    localparam int RS_TAG_W        = 6;

    typedef enum logic [RS_ALU_OP_WIDTH-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SLL  = 4'd1,
        ALU_XOR  = 4'd4,
        ALU_SRL  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_AND  = 4'd7,
        ALU_SUB  = 4'd10,
        ALU_SRA  = 4'd11,
        ALU_SLT  = 4'd12,
        ALU_SLTU = 4'd14
    } alu_op_e;

    // One source operand: when rdy is low the low RS_TAG_W bits of val hold the tag.
    typedef struct packed {
        logic                  rdy;
        logic [RS_XPR_LEN-1:0] val;
    } rs_opnd_t;

    typedef struct packed {
        logic                       valid;
        logic [RS_ALU_OP_WIDTH-1:0] op;
        rs_opnd_t                   src1;
        rs_opnd_t                   src2;
        logic [RS_TAG_W-1:0]        dst;
    } rs_entry_t;

    typedef struct packed {
        logic                  valid;
        logic [RS_TAG_W-1:0]   tag;
        logic [RS_XPR_LEN-1:0] data;
    } rs_wb_t;

    // Capture a broadcast into a waiting operand; wb0 wins when both buses match.
    function automatic rs_opnd_t rs_wakeup(input rs_opnd_t opnd, input rs_wb_t wb0, input rs_wb_t wb1);
        rs_opnd_t res;
        res = opnd;
        if (!opnd.rdy) begin
            if (wb0.valid && (wb0.tag == opnd.val[RS_TAG_W-1:0])) begin
                res.rdy = 1'b1;
                res.val = wb0.data;
            end else if (wb1.valid && (wb1.tag == opnd.val[RS_TAG_W-1:0])) begin
                res.rdy = 1'b1;
                res.val = wb1.data;
            end else begin
                res = opnd;
            end
        end else begin
            res = opnd;
        end
        return res;
    endfunction

endpackage

// File: rtl/rs_alu_chk.sv
// Protocol checker for rs_alu: flags a dispatch presented while the station is full.
module rs_alu_chk (
    input logic clk,
    input logic reset,
    input logic disp_valid,
    input logic full
);

    a_no_disp_when_full: assert property (@(posedge clk) disable iff (reset) !(disp_valid && full))
        else $warning("rs_alu: dispatch dropped while full");

endmodule

// File: rtl/rs_select.sv
// Issue picker for a reservation station. Returns a one-hot grant over the
// ready vector. With RS_ALU_AGE_SELECT_EN defined the oldest ready entry wins
// using the age matrix (age_i[i*NENT+j] set means entry i is older than j);
// otherwise the lowest-index ready entry wins.
module rs_select #(
    parameter int NENT = 8
) (
    input  logic [NENT-1:0]      ready_i,
`ifdef RS_ALU_AGE_SELECT_EN
    input  logic [NENT*NENT-1:0] age_i,
`endif
    output logic [NENT-1:0]      gnt_o,
    output logic                 valid_o
);

`ifdef RS_ALU_AGE_SELECT_EN
    logic blocked_s;

    // Grant the ready entry that no other ready entry is older than.
    always_comb begin
        gnt_o     = '0;
        blocked_s = 1'b0;
        for (int i = 0; i < NENT; i++) begin
            blocked_s = 1'b0;
            for (int j = 0; j < NENT; j++) begin
                if (ready_i[j] && age_i[j*NENT+i]) begin
                    blocked_s = 1'b1;
                end else begin
                    blocked_s = blocked_s;
                end
            end
            gnt_o[i] = ready_i[i] & ~blocked_s;
        end
        valid_o = |ready_i;
    end
`else
    logic found_s;

    // Grant the lowest-index ready entry.
    always_comb begin
        gnt_o   = '0;
        found_s = 1'b0;
        for (int i = 0; i < NENT; i++) begin
            if (ready_i[i] && !found_s) begin
                gnt_o[i] = 1'b1;
                found_s  = 1'b1;
            end else begin
                gnt_o[i] = 1'b0;
            end
        end
        valid_o = |ready_i;
    end
`endif

endmodule

// File: rtl/rs_alu.sv
// Reservation station for the integer ALU. Buffers dispatched micro-ops,
// wakes operands from two result buses (including same-cycle bypass at
// dispatch) and issues one ready micro-op per cycle with a valid/ready
// handshake. Optional feature macro: RS_ALU_AGE_SELECT_EN (oldest-first
// select via an age matrix; default is lowest-index select).
module rs_alu
    import rs_pkg::*;
#(
    parameter int NENT         = 8,
    parameter int TAG_W        = RS_TAG_W,
    parameter int XPR_LEN      = RS_XPR_LEN,
    parameter int ALU_OP_WIDTH = RS_ALU_OP_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    disp_valid,
    input  logic [ALU_OP_WIDTH-1:0] disp_op,
    input  logic [XPR_LEN-1:0]      disp_src1,
    input  logic [XPR_LEN-1:0]      disp_src2,
    input  logic                    disp_rdy1,
    input  logic                    disp_rdy2,
    input  logic [TAG_W-1:0]        disp_dst,
    output logic                    full,
    input  logic                    wb0_valid,
    input  logic [TAG_W-1:0]        wb0_tag,
    input  logic [XPR_LEN-1:0]      wb0_data,
    input  logic                    wb1_valid,
    input  logic [TAG_W-1:0]        wb1_tag,
    input  logic [XPR_LEN-1:0]      wb1_data,
    output logic                    iss_valid,
    input  logic                    iss_ready,
    output logic [ALU_OP_WIDTH-1:0] iss_op,
    output logic [XPR_LEN-1:0]      iss_in1,
    output logic [XPR_LEN-1:0]      iss_in2,
    output logic [TAG_W-1:0]        iss_dst
);

    rs_entry_t ent_q [NENT];
    rs_entry_t ent_d [NENT];

    // Selection is frozen while a presented micro-op is back-pressured.
    logic            hold_vld_q, hold_vld_d;
    logic [NENT-1:0] hold_q, hold_d;

    rs_wb_t          wb0_s, wb1_s;
    rs_entry_t       new_ent_s;
    rs_opnd_t        raw1_s, raw2_s;
    logic [NENT-1:0] valid_s, ready_s, free_oh_s, sel_gnt_s, gnt_s;
    logic            sel_vld_s, full_s, free_found_s, disp_fire_s, iss_fire_s, iss_valid_s;
    logic [ALU_OP_WIDTH-1:0] iss_op_s;
    logic [XPR_LEN-1:0]      iss_in1_s, iss_in2_s;
    logic [TAG_W-1:0]        iss_dst_s;

    // Pack the broadcast buses into the shared wakeup struct.
    always_comb begin
        wb0_s.valid = wb0_valid;
        wb0_s.tag   = wb0_tag;
        wb0_s.data  = wb0_data;
        wb1_s.valid = wb1_valid;
        wb1_s.tag   = wb1_tag;
        wb1_s.data  = wb1_data;
    end

    // Per-entry occupancy/readiness, fullness and lowest free slot from registered state.
    always_comb begin
        valid_s      = '0;
        ready_s      = '0;
        free_oh_s    = '0;
        free_found_s = 1'b0;
        for (int i = 0; i < NENT; i++) begin
            valid_s[i] = ent_q[i].valid;
            ready_s[i] = ent_q[i].valid & ent_q[i].src1.rdy & ent_q[i].src2.rdy;
            if (!ent_q[i].valid && !free_found_s) begin
                free_oh_s[i] = 1'b1;
                free_found_s = 1'b1;
            end else begin
                free_oh_s[i] = 1'b0;
            end
        end
        full_s      = &valid_s;
        disp_fire_s = disp_valid & ~full_s;
    end

    // Build the incoming entry, capturing same-cycle broadcasts for waiting operands.
    always_comb begin
        raw1_s          = {1'b0, disp_src1};
        raw2_s          = {1'b0, disp_src2};
        new_ent_s       = '0;
        new_ent_s.valid = 1'b1;
        new_ent_s.op    = disp_op;
        new_ent_s.dst   = disp_dst;
        if (disp_rdy1) begin
            new_ent_s.src1 = {1'b1, disp_src1};
        end else begin
            new_ent_s.src1 = rs_wakeup(raw1_s, wb0_s, wb1_s);
        end
        if (disp_rdy2) begin
            new_ent_s.src2 = {1'b1, disp_src2};
        end else begin
            new_ent_s.src2 = rs_wakeup(raw2_s, wb0_s, wb1_s);
        end
    end

`ifdef RS_ALU_AGE_SELECT_EN
    logic [NENT*NENT-1:0] age_q, age_d;

    // New entry is older than nobody and younger than every currently valid entry.
    always_comb begin
        age_d = age_q;
        if (disp_fire_s) begin
            for (int k = 0; k < NENT; k++) begin
                if (free_oh_s[k]) begin
                    for (int j = 0; j < NENT; j++) begin
                        age_d[k*NENT+j] = 1'b0;
                        age_d[j*NENT+k] = valid_s[j];
                    end
                end else begin
                    age_d = age_d;
                end
            end
        end else begin
            age_d = age_q;
        end
    end

    // Age matrix register.
    always_ff @(posedge clk) begin
        if (reset) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end
`endif

    rs_select #(
        .NENT    (NENT)
    ) u_select (
        .ready_i (ready_s),
`ifdef RS_ALU_AGE_SELECT_EN
        .age_i   (age_q),
`endif
        .gnt_o   (sel_gnt_s),
        .valid_o (sel_vld_s)
    );

    // Effective grant, issue mux and handshake; outputs are zero without a grant.
    always_comb begin
        gnt_s       = hold_vld_q ? hold_q : sel_gnt_s;
        iss_valid_s = hold_vld_q | sel_vld_s;
        iss_fire_s  = iss_valid_s & iss_ready;
        iss_op_s    = '0;
        iss_in1_s   = '0;
        iss_in2_s   = '0;
        iss_dst_s   = '0;
        for (int i = 0; i < NENT; i++) begin
            if (gnt_s[i]) begin
                iss_op_s  = ent_q[i].op;
                iss_in1_s = ent_q[i].src1.val;
                iss_in2_s = ent_q[i].src2.val;
                iss_dst_s = ent_q[i].dst;
            end else begin
                iss_op_s  = iss_op_s;
            end
        end
        hold_vld_d = iss_valid_s & ~iss_ready & ~flush;
        hold_d     = hold_vld_d ? gnt_s : '0;
    end

    // Entry next state: wakeup, free on issue, write on dispatch, flush last (highest priority).
    always_comb begin
        for (int i = 0; i < NENT; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].valid) begin
                ent_d[i].src1 = rs_wakeup(ent_q[i].src1, wb0_s, wb1_s);
                ent_d[i].src2 = rs_wakeup(ent_q[i].src2, wb0_s, wb1_s);
            end else begin
                ent_d[i] = ent_q[i];
            end
            if (iss_fire_s && gnt_s[i]) begin
                ent_d[i].valid = 1'b0;
            end else begin
                ent_d[i].valid = ent_d[i].valid;
            end
            if (disp_fire_s && free_oh_s[i]) begin
                ent_d[i] = new_ent_s;
            end else begin
                ent_d[i] = ent_d[i];
            end
            if (flush) begin
                ent_d[i].valid = 1'b0;
            end else begin
                ent_d[i].valid = ent_d[i].valid;
            end
        end
    end

    // Entry storage and issue-hold registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NENT; i++) begin
                ent_q[i] <= '0;
            end
            hold_vld_q <= 1'b0;
            hold_q     <= '0;
        end else begin
            for (int i = 0; i < NENT; i++) begin
                ent_q[i] <= ent_d[i];
            end
            hold_vld_q <= hold_vld_d;
            hold_q     <= hold_d;
        end
    end

    assign full      = full_s;
    assign iss_valid = iss_valid_s;
    assign iss_op    = iss_op_s;
    assign iss_in1   = iss_in1_s;
    assign iss_in2   = iss_in2_s;
    assign iss_dst   = iss_dst_s;

    rs_alu_chk u_chk (
        .clk        (clk),
        .reset      (reset),
        .disp_valid (disp_valid),
        .full       (full_s)
    );

endmodule

// File: tb/tb_rs_alu.sv
// Scoreboard bench for rs_alu: directed dispatch/wakeup sequences push the
// expected issue tuple; a negedge monitor pops and compares on every accepted
// issue and also checks that back-pressured outputs hold steady.
module tb_rs_alu;
    import rs_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        disp_valid = 1'b0;
    logic [3:0]  disp_op = 4'd0;
    logic [31:0] disp_src1 = 32'd0, disp_src2 = 32'd0;
    logic        disp_rdy1 = 1'b0, disp_rdy2 = 1'b0;
    logic [5:0]  disp_dst = 6'd0;
    logic        full;
    logic        wb0_valid = 1'b0, wb1_valid = 1'b0;
    logic [5:0]  wb0_tag = 6'd0, wb1_tag = 6'd0;
    logic [31:0] wb0_data = 32'd0, wb1_data = 32'd0;
    logic        iss_valid;
    logic        iss_ready = 1'b0;
    logic [3:0]  iss_op;
    logic [31:0] iss_in1, iss_in2;
    logic [5:0]  iss_dst;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [5:0]  dst;
    } iss_t;

    iss_t exp_q[$];
    iss_t exp_e;
    iss_t prev_out;
    logic prev_hold = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic [5:0] first_dst, second_dst;

    rs_alu dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .disp_valid (disp_valid),
        .disp_op    (disp_op),
        .disp_src1  (disp_src1),
        .disp_src2  (disp_src2),
        .disp_rdy1  (disp_rdy1),
        .disp_rdy2  (disp_rdy2),
        .disp_dst   (disp_dst),
        .full       (full),
        .wb0_valid  (wb0_valid),
        .wb0_tag    (wb0_tag),
        .wb0_data   (wb0_data),
        .wb1_valid  (wb1_valid),
        .wb1_tag    (wb1_tag),
        .wb1_data   (wb1_data),
        .iss_valid  (iss_valid),
        .iss_ready  (iss_ready),
        .iss_op     (iss_op),
        .iss_in1    (iss_in1),
        .iss_in2    (iss_in2),
        .iss_dst    (iss_dst)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [3:0] op, input logic [31:0] s1, input logic r1,
                        input logic [31:0] s2, input logic r2, input logic [5:0] d);
        disp_valid = 1'b1;
        disp_op    = op;
        disp_src1  = s1;
        disp_rdy1  = r1;
        disp_src2  = s2;
        disp_rdy2  = r2;
        disp_dst   = d;
    endtask

    task automatic expect_iss(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [5:0] d);
        exp_q.push_back({op, a, b, d});
    endtask

    task automatic bcast(input int bus, input logic [5:0] tag, input logic [31:0] data);
        if (bus == 0) begin
            wb0_valid = 1'b1; wb0_tag = tag; wb0_data = data;
        end else begin
            wb1_valid = 1'b1; wb1_tag = tag; wb1_data = data;
        end
    endtask

    task automatic idle();
        disp_valid = 1'b0;
        wb0_valid  = 1'b0;
        wb1_valid  = 1'b0;
    endtask

    // Monitor: compare accepted issues against the scoreboard, check stall stability.
    always @(negedge clk) begin
        if (!reset) begin
            if (prev_hold) begin
                total++;
                if (!iss_valid || ({iss_op, iss_in1, iss_in2, iss_dst} !== prev_out)) begin
                    bad++;
                    $display("FAIL stall_stable: got v=%b %h want v=1 %h", iss_valid,
                             {iss_op, iss_in1, iss_in2, iss_dst}, prev_out);
                end
            end
            if (iss_valid && iss_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL issue_unexpected: got op=%h in1=%h in2=%h dst=%h want none",
                             iss_op, iss_in1, iss_in2, iss_dst);
                end else begin
                    exp_e = exp_q.pop_front();
                    if ({iss_op, iss_in1, iss_in2, iss_dst} !== exp_e) begin
                        bad++;
                        $display("FAIL issue: got op=%h in1=%h in2=%h dst=%h want op=%h in1=%h in2=%h dst=%h",
                                 iss_op, iss_in1, iss_in2, iss_dst, exp_e.op, exp_e.in1, exp_e.in2, exp_e.dst);
                    end
                end
            end
            prev_hold = iss_valid && !iss_ready && !flush;
            prev_out  = {iss_op, iss_in1, iss_in2, iss_dst};
        end else begin
            prev_hold = 1'b0;
        end
    end

    initial begin
        // Reset state
        step(); step();
        chk("rst_full", full, 0);
        chk("rst_valid", iss_valid, 0);
        chk("rst_op", iss_op, 0);
        chk("rst_in1", iss_in1, 0);
        chk("rst_in2", iss_in2, 0);
        chk("rst_dst", iss_dst, 0);
        reset = 1'b0;
        step();

        // Ready-at-dispatch ADD issues the next cycle
        iss_ready = 1'b1;
        disp(ALU_ADD, 32'd5, 1'b1, 32'd7, 1'b1, 6'd3);
        expect_iss(ALU_ADD, 32'd5, 32'd7, 6'd3);
        step(); idle();
        chk("add_valid", iss_valid, 1);
        step();
        chk("add_idle", iss_valid, 0);

        // Wakeup via wb1
        disp(ALU_SUB, 32'd9, 1'b0, 32'd1, 1'b1, 6'd4);
        expect_iss(ALU_SUB, 32'h20, 32'd1, 6'd4);
        step(); idle();
        chk("wake_wait", iss_valid, 0);
        bcast(1, 6'd9, 32'h20);
        step(); idle();
        chk("wake_valid", iss_valid, 1);
        step();
        chk("wake_idle", iss_valid, 0);

        // Both buses match: wb0 data wins
        disp(ALU_XOR, 32'd10, 1'b0, 32'd3, 1'b1, 6'd6);
        expect_iss(ALU_XOR, 32'hA0, 32'd3, 6'd6);
        step(); idle();
        bcast(0, 6'd10, 32'hA0);
        bcast(1, 6'd10, 32'hB0);
        step(); idle();
        chk("prio_valid", iss_valid, 1);
        step();

        // Same-cycle bypass at dispatch
        disp(ALU_ADD, 32'd2, 1'b1, 32'd12, 1'b0, 6'd5);
        bcast(0, 6'd12, 32'hFFFF_FFFF);
        expect_iss(ALU_ADD, 32'd2, 32'hFFFF_FFFF, 6'd5);
        step(); idle();
        chk("bypass_valid", iss_valid, 1);
        step();
        chk("bypass_idle", iss_valid, 0);

        // Fill with pending tags 16..23 under back-pressure
        iss_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            disp(ALU_ADD, 32'(16 + i), 1'b0, 32'(i), 1'b1, 6'(20 + i));
            step();
            if (i == 6) chk("fill_not_full", full, 0);
        end
        idle();
        chk("fill_full", full, 1);
        chk("fill_none_ready", iss_valid, 0);
        disp(ALU_AND, 32'h99, 1'b1, 32'h98, 1'b1, 6'd63);
        step(); idle();
        chk("drop_full", full, 1);
        chk("drop_no_issue", iss_valid, 0);

        // Wake entry 3, stall a cycle, then accept; slot visible next cycle
        bcast(0, 6'd19, 32'h300);
        step(); idle();
        chk("e3_valid", iss_valid, 1);
        chk("e3_dst", iss_dst, 23);
        step();
        iss_ready = 1'b1;
        expect_iss(ALU_ADD, 32'h300, 32'd3, 6'd23);
        step();
        iss_ready = 1'b0;
        chk("free_full", full, 0);

        // Select order: refill 3, put X in entry 6 then Y in entry 2, wake both together
        disp(ALU_OR, 32'd40, 1'b0, 32'd0, 1'b1, 6'd7);
        step(); idle();
        chk("refill_full", full, 1);
        bcast(0, 6'd22, 32'h600);
        iss_ready = 1'b1;
        expect_iss(ALU_ADD, 32'h600, 32'd6, 6'd26);
        step(); idle();
        step();
        iss_ready = 1'b0;
        chk("e6_free", full, 0);
        disp(ALU_SUB, 32'd50, 1'b0, 32'h66, 1'b1, 6'd36);
        step(); idle();
        bcast(0, 6'd18, 32'h200);
        iss_ready = 1'b1;
        expect_iss(ALU_ADD, 32'h200, 32'd2, 6'd22);
        step(); idle();
        step();
        iss_ready = 1'b0;
        chk("e2_free", full, 0);
        disp(ALU_SUB, 32'd50, 1'b0, 32'h22, 1'b1, 6'd32);
        step(); idle();
        chk("xy_full", full, 1);
`ifdef RS_ALU_AGE_SELECT_EN
        first_dst  = 6'd36;
        second_dst = 6'd32;
        expect_iss(ALU_SUB, 32'h50, 32'h66, 6'd36);
        expect_iss(ALU_SUB, 32'h50, 32'h22, 6'd32);
`else
        first_dst  = 6'd32;
        second_dst = 6'd36;
        expect_iss(ALU_SUB, 32'h50, 32'h22, 6'd32);
        expect_iss(ALU_SUB, 32'h50, 32'h66, 6'd36);
`endif
        bcast(1, 6'd50, 32'h50);
        iss_ready = 1'b1;
        step(); idle();
        chk("order_first", iss_dst, first_dst);
        step();
        chk("order_second", iss_dst, second_dst);
        step();
        chk("order_idle", iss_valid, 0);
        iss_ready = 1'b0;

        // Back-pressured issue holds even when a lower entry wakes; then flush + dispatch
        bcast(0, 6'd20, 32'h400);
        step(); idle();
        chk("bp_valid", iss_valid, 1);
        chk("bp_dst", iss_dst, 24);
        bcast(0, 6'd16, 32'h100);
        step(); idle();
        chk("bp_hold_dst", iss_dst, 24);
        flush = 1'b1;
        disp(ALU_ADD, 32'd1, 1'b1, 32'd1, 1'b1, 6'd9);
        step();
        flush = 1'b0;
        idle();
        chk("flush_valid", iss_valid, 0);
        chk("flush_full", full, 0);
        chk("flush_in1", iss_in1, 0);
        step();
        chk("flush_squashed", iss_valid, 0);

        // Back-to-back dispatch and issue
        iss_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            disp(ALU_SLL, 32'(10 + i), 1'b1, 32'(i + 1), 1'b1, 6'(40 + i));
            expect_iss(ALU_SLL, 32'(10 + i), 32'(i + 1), 6'(40 + i));
            step();
        end
        idle();
        chk("stream_last_valid", iss_valid, 1);
        step();
        chk("stream_idle", iss_valid, 0);
        chk("drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rs_alu.md
# rs_alu

Reservation station in front of the integer ALU: buffers dispatched ALU micro-ops with their operands, captures missing operands from result-bus broadcasts, and issues one ready micro-op per cycle to the ALU stage as its `op`/`in1`/`in2` source. It sits between rename/dispatch and the ALU execute pipeline register, and acts as the initiator side of the ALU operand interface.

## Interface
Parameters:
- `NENT`, 8: number of entries, a power of two from 2 to 16.
- `TAG_W`, 6: rename-register tag width.
- `XPR_LEN` and `ALU_OP_WIDTH`: taken from the shared headers (32 and 4).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  squash every entry (mispredict recovery).
- `disp_valid`  in  1  dispatch request.
- `disp_op`  in  ALU_OP_WIDTH  ALU opcode.
- `disp_src1`, `disp_src2`  in  XPR_LEN  operand value, or the source tag in the low TAG_W bits when the operand is not ready.
- `disp_rdy1`, `disp_rdy2`  in  1  operand value valid.
- `disp_dst`  in  TAG_W  destination tag.
- `full`  out  1  all entries occupied.
- `wb0_valid`, `wb1_valid`  in  1  result broadcast valid.
- `wb0_tag`, `wb1_tag`  in  TAG_W  broadcast tag.
- `wb0_data`, `wb1_data`  in  XPR_LEN  broadcast value.
- `iss_valid`  out  1  a ready entry is presented.
- `iss_ready`  in  1  ALU stage accepts.
- `iss_op`  out  ALU_OP_WIDTH  opcode to the ALU.
- `iss_in1`, `iss_in2`  out  XPR_LEN  operands to the ALU.
- `iss_dst`  out  TAG_W  destination tag.

## Operation
- Entry state: valid, op, value/tag and ready flag per operand, dst.
- Dispatch: when `disp_valid` is high and `full` is low, the lowest-index free entry is written.
  - Each not-ready operand whose tag matches a same-cycle wb0/wb1 broadcast is stored as ready, with that broadcast's data.
- Wakeup: every valid entry compares each not-ready operand tag against wb0 and wb1.
  - A match sets the operand ready and latches the data.
  - If both buses match, wb0 wins.
- Ready entry: valid with both operands ready.
- Select: see Configuration. `iss_*` is driven combinationally from the selected entry's registers.
  - Outputs are zero when `iss_valid` is low.
- Issue handshake: the entry is freed at the clock edge where `iss_valid && iss_ready`.
  - `iss_*` must stay stable while `iss_valid` is high and `iss_ready` is low, unless `flush` is asserted.
- `full` is computed from registered valid bits only. An entry freed in the same cycle cannot accept a dispatch that cycle.
- Dispatch while `full` is ignored, and an assertion fires.
- `flush`: all valid bits clear at the edge. It has priority over a same-cycle dispatch, wakeup and issue; the issue is not counted as accepted.

## Timing
- Reset values: all entries invalid, `full`=0, `iss_valid`=0, and all `iss_*` data outputs 0.
- A dispatch at edge N with both operands ready (or captured via bypass) gives `iss_valid` in cycle N+1 at the earliest.
- A wakeup broadcast in cycle N makes the entry issuable in cycle N+1.
- Throughput: one dispatch and one issue per cycle, sustained.
- A free slot becomes visible to `full` in the cycle after the freeing edge.

## Configuration
- `RS_ALU_AGE_SELECT_EN` defined:
  - An NENT×NENT age matrix is maintained. A dispatched row is set older-than-none, and its column is marked younger-than-all-valid.
  - Select picks the oldest ready entry.
- `RS_ALU_AGE_SELECT_EN` not defined:
  - Select picks the lowest-index ready entry.
  - No age state is built.

## Structure
- Shared package `rs_pkg`: the entry struct type, the tag width, and the wakeup-bus struct. Other reservation stations reuse these.
- Sub-module `rs_select`: takes a NENT-bit ready vector (plus the age matrix when enabled) and returns a one-hot grant and a valid flag.

## Test plan
- Ready-at-dispatch ADD: src1=5, src2=7, dst=3 at cycle 0, `iss_ready`=1 → cycle 1: `iss_valid`=1, `iss_op`=ADD, `iss_in1`=5, `iss_in2`=7, `iss_dst`=3. Cycle 2: `iss_valid`=0.
- Wakeup: dispatch SUB with src1 tag 9 not ready, src2=1. Broadcast wb1 tag 9 data 0x20 at cycle 4 → cycle 5 issues in1=0x20, in2=1.
- Same-cycle bypass: dispatch with src2 tag 12 while wb0 tag 12 data 0xFFFF_FFFF is broadcast → the entry issues the next cycle with in2=0xFFFF_FFFF.
- Fill and stall: 8 dispatches with tags pending and `iss_ready`=0 → `full`=1 after the 8th edge. A 9th dispatch is dropped and the assertion fires. Wake one entry and accept it → `full`=0 one cycle later.
- Select order: entries 6 then 2 dispatched in that order and woken in the same cycle → with `RS_ALU_AGE_SELECT_EN`, entry 6 issues first; without it, entry 2 issues first.
- Flush with backpressure: `iss_valid`=1, `iss_ready`=0, flush plus dispatch in the same cycle → next cycle all entries invalid, `iss_valid`=0, `full`=0.
